hc138_cs_arbiter: RTL and testbench

//  Round-robin chip-select scheduler that drives one 74HC138 decoder.

---
 rtl/hc138_arb_pkg.sv | 21 ++
 rtl/hc138_cs_arbiter_rr_pick8.sv | 26 ++
 rtl/hc138_cs_arbiter.sv | 128 ++++++++++++
 tb/tb_hc138_cs_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hc138_arb_pkg.sv
// Shared types and constants for the HC138 chip-select arbiter.
// The decoder enable triple is ordered {g1, g2a_n, g2b_n}.
package hc138_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [2:0] DEC_OFF = 3'b011;
    localparam logic [2:0] DEC_ON  = 3'b100;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/hc138_cs_arbiter_rr_pick8.sv
// Rotate-priority encoder: returns the first set request at or after ptr,
// wrapping modulo 8.
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       valid,
    output logic [2:0] idx
);

    logic [2:0] cand;

    // Walk from the farthest offset down so the nearest hit is assigned last.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr + 3'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/hc138_cs_arbiter.sv
// Round-robin chip-select scheduler driving one 74HC138 decoder with
// address setup, bounded hold and recovery; all outputs registered.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | decoder off, waiting for any request
//  SETUP   | address and grant valid, decoder still off
//  ACTIVE  | decoder enabled, selected output low
//  RECOVER | decoder off, address held, grant dropped
module hc138_cs_arbiter
    import hc138_arb_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int MAX_HOLD       = 16,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] a,
    output logic       g1,
    output logic       g2a_n,
    output logic       g2b_n,
    output logic       busy
);

    localparam int CNT_W = $clog2(max3(SETUP_CYCLES, MAX_HOLD, RECOVER_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOVER_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       a_q, a_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       dec_q, dec_d;
    logic             busy_q, busy_d;
    logic             pick_valid;
    logic [2:0]       pick_idx;

    rr_pick8 u_pick (
        .req  (req),
        .ptr  (rr_ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // a_q doubles as the current winner: it is loaded at arbitration and held until IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        grant_d  = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SETUP;
                    a_d     = pick_idx;
                    grant_d = 8'd1 << pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (!req[a_q]) begin
                    state_d  = ST_RECOVER;
                    grant_d  = '0;
                    rr_ptr_d = a_q + 3'd1;
                    cnt_d    = '0;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!req[a_q] || cnt_q == HOLD_LAST) begin
                    state_d  = ST_RECOVER;
                    grant_d  = '0;
                    rr_ptr_d = a_q + 3'd1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        dec_d  = (state_d == ST_ACTIVE) ? DEC_ON : DEC_OFF;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            a_q      <= '0;
            grant_q  <= '0;
            dec_q    <= DEC_OFF;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            grant_q  <= grant_d;
            dec_q    <= dec_d;
            busy_q   <= busy_d;
        end
    end

    assign grant = grant_q;
    assign a     = a_q;
    assign busy  = busy_q;
    assign {g1, g2a_n, g2b_n} = dec_q;

endmodule

// File: tb/tb_hc138_cs_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants (index, ACTIVE length),
// a negedge monitor pops one entry per completed grant and compares.
module tb_hc138_cs_arbiter;

    typedef struct {
        int idx;
        int len;
    } exp_t;

    logic       clk;
    logic       rst_a, rst_b;
    logic [7:0] req_a, req_b;
    logic [7:0] grant_a, grant_b;
    logic [2:0] a_a, a_b;
    logic       g1_a, g2a_a, g2b_a, busy_a;
    logic       g1_b, g2a_b, g2b_b, busy_b;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    bit         in_g[2];
    bit         prev_busy[2];
    int         act_c[2];
    logic [7:0] cur_g[2];
    logic [2:0] cur_a[2];

    hc138_cs_arbiter dut_a (
        .clk(clk), .rst_n(rst_a), .req(req_a), .grant(grant_a), .a(a_a),
        .g1(g1_a), .g2a_n(g2a_a), .g2b_n(g2b_a), .busy(busy_a)
    );

    hc138_cs_arbiter #(.SETUP_CYCLES(3), .MAX_HOLD(4), .RECOVER_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_b), .req(req_b), .grant(grant_b), .a(a_b),
        .g1(g1_b), .g2a_n(g2a_b), .g2b_n(g2b_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input int got, input int want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    endtask

    task automatic push(input int d, input int idx, input int len);
        exp_t e;
        e.idx = idx;
        e.len = len;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon_step(input int d, input logic rstn, input logic [7:0] g,
                            input logic [2:0] av, input logic e1, input logic e2,
                            input logic e3, input logic bz);
        exp_t e;
        bit   have;
        if (!rstn) begin
            in_g[d]      = 1'b0;
            prev_busy[d] = 1'b0;
            return;
        end
        check($countones(g) <= 1, "grant_onehot", $countones(g), 1);
        check(({e1, e2, e3} == 3'b100 && g != 0) || {e1, e2, e3} == 3'b011,
              "dec_coherent", {e1, e2, e3}, (g != 0) ? 4 : 3);
        if (g != 0 && !in_g[d]) begin
            check(prev_busy[d] == 1'b0, "idle_gap", prev_busy[d], 0);
            in_g[d]  = 1'b1;
            cur_g[d] = g;
            cur_a[d] = av;
            act_c[d] = 0;
        end else if (g != 0) begin
            check(g == cur_g[d] && av == cur_a[d], "grant_stable", {g, av}, {cur_g[d], cur_a[d]});
        end
        if (in_g[d] && g != 0 && e1) act_c[d]++;
        if (in_g[d] && g == 0) begin
            in_g[d] = 1'b0;
            have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
                check(1'b0, "unexpected_grant", cur_a[d], -1);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check(cur_a[d] == 3'(e.idx), "grant_index", cur_a[d], e.idx);
                check(cur_g[d] == (8'd1 << e.idx), "grant_vector", cur_g[d], 1 << e.idx);
                check(act_c[d] == e.len, "active_cycles", act_c[d], e.len);
                check(av == cur_a[d], "addr_held", av, cur_a[d]);
            end
        end
        prev_busy[d] = bz;
    endtask

    always @(negedge clk) begin
        mon_step(0, rst_a, grant_a, a_a, g1_a, g2a_a, g2b_a, busy_a);
        mon_step(1, rst_b, grant_b, a_b, g1_b, g2a_b, g2b_b, busy_b);
    end

    task automatic wait_drain(input int d, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) return;
        end
        check(1'b0, "drain_timeout", (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic wait_g1_a(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (g1_a) return;
        end
        check(1'b0, "g1_timeout", 0, 1);
    endtask

    task automatic test_a();
        // single request, 3 ACTIVE cycles
        @(posedge clk); #1;
        push(0, 5, 3);
        req_a = 8'h20;
        @(posedge clk); #1;
        check(grant_a == 8'h20 && a_a == 3'd5, "setup_grant", {grant_a, a_a}, {8'h20, 3'd5});
        check(g1_a == 1'b0 && busy_a == 1'b1, "setup_dec_off", {g1_a, busy_a}, 1);
        @(posedge clk); #1;
        check({g1_a, g2a_a, g2b_a} == 3'b100, "active_enable", {g1_a, g2a_a, g2b_a}, 4);
        repeat (2) @(posedge clk);
        #1 req_a = 8'h00;
        wait_drain(0, 20);
        check(dut_a.rr_ptr_q == 3'd6, "rr_ptr_after_5", dut_a.rr_ptr_q, 6);

        // forced release and re-grant with no competitor
        @(posedge clk); #1;
        push(0, 0, 16);
        push(0, 0, 16);
        req_a = 8'h01;
        wait_drain(0, 120);
        req_a = 8'h00;
        repeat (3) @(posedge clk);

        // non-winner noise on req[6] while 3 is granted
        #1;
        push(0, 3, 5);
        req_a = 8'h08;
        repeat (6) begin
            @(posedge clk); #1;
            req_a[6] = ~req_a[6];
        end
        req_a[3] = 1'b0;
        wait_drain(0, 20);
        repeat (2) @(posedge clk);

        // asynchronous reset in the middle of ACTIVE
        #1;
        req_a = 8'h80;
        wait_g1_a(20);
        #2 rst_a = 1'b0;
        #1;
        check({g1_a, g2a_a, g2b_a} == 3'b011, "rst_dec_off", {g1_a, g2a_a, g2b_a}, 3);
        check(grant_a == 8'h00 && busy_a == 1'b0, "rst_grant_busy", {grant_a, busy_a}, 0);
        check(a_a == 3'd0 && dut_a.rr_ptr_q == 3'd0, "rst_addr_ptr", {a_a, dut_a.rr_ptr_q}, 0);
        req_a = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_a = 1'b1;
        @(posedge clk); #1;
        check(busy_a == 1'b0 && dut_a.rr_ptr_q == 3'd0, "post_rst_idle", {busy_a, dut_a.rr_ptr_q}, 0);

        // pointer restarted at 0: bits 1,2 pending -> 1 wins
        push(0, 1, 2);
        req_a = 8'h06;
        wait_g1_a(20);
        @(posedge clk); #1;
        req_a = 8'h00;
        wait_drain(0, 20);
    endtask

    task automatic test_b();
        // round robin 0..7,0 with req=FF (pushed before reset release)
        wait_drain(1, 300);
        req_b = 8'h00;
        repeat (3) @(posedge clk);

        // SETUP abort: req[2] dropped in the 2nd SETUP cycle
        #1;
        push(1, 2, 0);
        req_b = 8'h04;
        @(posedge clk);
        @(posedge clk);
        #1 req_b = 8'h00;
        wait_drain(1, 20);
        check(dut_b.rr_ptr_q == 3'd3, "abort_rr_ptr", dut_b.rr_ptr_q, 3);
        repeat (3) @(posedge clk);

        // pointer at 3: 3 first, then 2 after the forced release
        #1;
        push(1, 3, 4);
        push(1, 2, 4);
        req_b = 8'h0C;
        wait_drain(1, 60);
        req_b = 8'h00;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        req_a = 8'h00;
        req_b = 8'hFF;
        for (int i = 0; i < 9; i++) push(1, i % 8, 4);
        #12;
        check(grant_a == 8'h00 && a_a == 3'd0, "reset_grant_addr", {grant_a, a_a}, 0);
        check({g1_a, g2a_a, g2b_a} == 3'b011, "reset_dec", {g1_a, g2a_a, g2b_a}, 3);
        check(busy_a == 1'b0 && busy_b == 1'b0, "reset_busy", {busy_a, busy_b}, 0);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        fork
            test_a();
            test_b();
        join
        check(q0.size() == 0, "q0_empty", q0.size(), 0);
        check(q1.size() == 0, "q1_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
